lane_sum_acc: RTL and testbench

LANE_SUM_ACC -- requirements
Module: lane_sum_acc

---
 rtl/lane_sum_pkg.sv | 19 +
 rtl/lane_adder_tree.sv | 21 ++
 rtl/lane_sum_acc.sv | 115 +++++++++++
 tb/tb_lane_sum_acc.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_sum_pkg.sv
// Shared FSM state type and default parameters for lane_sum_acc.
// FE_DATA_W may be supplied by the build; it falls back to 32.
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif

package lane_sum_pkg;

  localparam int LS_DATA_W  = `FE_DATA_W;
  localparam int LS_LANE_W  = 8;
  localparam int LS_MAX_LEN = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational sum of all zero-extended LANE_W lanes of one DATA_W word.
// SUM_W = LANE_W + clog2(DATA_W/LANE_W) is wide enough that the sum never wraps.
module lane_adder_tree #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int SUM_W  = 10
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [SUM_W-1:0]  sum_o
);

  localparam int NUM_LANES = DATA_W / LANE_W;

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sum_o = sum_o + SUM_W'(data_i[i*LANE_W +: LANE_W]);
    end
  end

endmodule

// File: rtl/lane_sum_acc.sv
// Accumulates lane sums over a len-beat job; result valid 1 cycle after the last beat, held until out_ready_i.
// Build option LANE_SUM_SAT_EN: saturate at 2^DATA_W-1 instead of wrapping on overflow.
module lane_sum_acc
  import lane_sum_pkg::*;
#(
  parameter int  DATA_W    = LS_DATA_W,
  parameter int  LANE_W    = LS_LANE_W,
  parameter int  MAX_LEN   = LS_MAX_LEN,
  localparam int NUM_LANES = DATA_W / LANE_W,
  localparam int LEN_W     = $clog2(MAX_LEN + 1),
  localparam int SUM_W     = LANE_W + $clog2(NUM_LANES)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              done_o,
  output logic              ovf_o,
  output logic              busy_o
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   len_clamped;
  // Top bit of the accumulator is the sticky overflow flag for the job.
  logic [DATA_W:0]    acc_q, acc_d;
  logic [DATA_W:0]    acc_sum;
  logic               done_q, done_d;
  logic               ovf_next;
  logic [SUM_W-1:0]   beat_sum;
  logic               beat;

  lane_adder_tree #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .SUM_W  (SUM_W)
  ) u_tree (
    .data_i (in_data_i),
    .sum_o  (beat_sum)
  );

  assign beat        = in_valid_i && (state_q == ST_ACCUM);
  assign len_clamped = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
  assign acc_sum     = {1'b0, acc_q[DATA_W-1:0]} + (DATA_W+1)'(beat_sum);
  assign ovf_next    = acc_q[DATA_W] | acc_sum[DATA_W];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d = '0;
          rem_d = len_clamped;
          if (len_clamped == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          rem_d = rem_q - LEN_W'(1);
`ifdef LANE_SUM_SAT_EN
          acc_d = ovf_next ? {1'b1, {DATA_W{1'b1}}} : {1'b0, acc_sum[DATA_W-1:0]};
`else
          acc_d = {ovf_next, acc_sum[DATA_W-1:0]};
`endif
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  assign in_ready_o  = (state_q == ST_ACCUM);
  assign out_valid_o = (state_q == ST_DONE);
  assign out_data_o  = acc_q[DATA_W-1:0];
  assign done_o      = done_q;
  assign ovf_o       = acc_q[DATA_W];
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lane_sum_acc.sv
// Scoreboard bench for lane_sum_acc: a 32-bit instance for the main jobs and a 16-bit one for overflow.
`timescale 1ns/1ps
module tb_lane_sum_acc;

  localparam int DW   = 32;
  localparam int LW   = 8;
  localparam int ML   = 256;
  localparam int LENW = $clog2(ML + 1);
`ifdef LANE_SUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, done, ovf, busy;
  logic [LENW-1:0] len = '0;
  logic [DW-1:0] in_data = '0, out_data;

  logic start16 = 1'b0, in_valid16 = 1'b0;
  logic in_ready16, out_valid16, done16, ovf16, busy16;
  logic [LENW-1:0] len16 = '0;
  logic [15:0] in_data16 = '0, out_data16;

  typedef struct {
    longint unsigned data;
    bit              ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp16_q[$];
  logic [DW-1:0] beat_q[$];
  int n_tests = 0, n_fail = 0;
  int rdy_pct = 100;
  int done_cnt = 0, done16_cnt = 0;
  bit hold_vld = 1'b0;
  logic [DW-1:0] hold_dat = '0;

  always #5 clk = ~clk;

  lane_sum_acc #(.DATA_W(DW), .LANE_W(LW), .MAX_LEN(ML)) dut (
    .clk_i(clk), .arst_i(arst), .start_i(start), .len_i(len),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .done_o(done), .ovf_o(ovf), .busy_o(busy)
  );

  lane_sum_acc #(.DATA_W(16), .LANE_W(8), .MAX_LEN(ML)) dut16 (
    .clk_i(clk), .arst_i(arst), .start_i(start16), .len_i(len16),
    .in_valid_i(in_valid16), .in_data_i(in_data16), .in_ready_o(in_ready16),
    .out_valid_o(out_valid16), .out_data_o(out_data16), .out_ready_i(out_ready),
    .done_o(done16), .ovf_o(ovf16), .busy_o(busy16)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned lane_sum(input logic [DW-1:0] d);
    longint unsigned s = 0;
    for (int i = 0; i < DW / LW; i++) s += longint'((d >> (LW * i)) & 32'h0000_00FF);
    return s;
  endfunction

  // Result acceptor: random backpressure, updated well clear of both clock edges.
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
  end

  always @(negedge clk) begin
    exp_t e;
    if (arst) begin
      done_cnt = 0;
      hold_vld = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (hold_vld) chk("hold_data", out_data, hold_dat);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("result_data", out_data, e.data);
            chk("result_ovf", ovf, e.ovf);
            chk("done_pulses", done_cnt, 1);
          end
          done_cnt = 0;
          hold_vld = 1'b0;
        end else begin
          hold_vld = 1'b1;
          hold_dat = out_data;
        end
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (arst) begin
      done16_cnt = 0;
    end else begin
      if (done16) done16_cnt++;
      if (out_valid16 && out_ready) begin
        if (exp16_q.size() == 0) begin
          chk("w16_unexpected_result", 1, 0);
        end else begin
          e = exp16_q.pop_front();
          chk("w16_result_data", out_data16, e.data);
          chk("w16_result_ovf", ovf16, e.ovf);
          chk("w16_done_pulses", done16_cnt, 1);
        end
        done16_cnt = 0;
      end
    end
  end

  task automatic rst_chk(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  // Called at posedge+1. gap<0 means random idle cycles between beats.
  task automatic job(input int len_req, input int gap, input int abort_after, input bit stop_in_done);
    int eff, g, guard;
    bit hit;
    longint unsigned tot;
    exp_t e;
    eff = (len_req > ML) ? ML : len_req;
    tot = 0;
    for (int i = 0; i < eff; i++) tot += lane_sum(beat_q[i]);
    e.ovf  = (tot > 64'hFFFF_FFFF);
    e.data = e.ovf ? (SAT ? 64'hFFFF_FFFF : (tot & 64'hFFFF_FFFF)) : tot;
    exp_q.push_back(e);
    start = 1'b1;
    len   = LENW'(len_req);
    @(posedge clk); #1;
    start = 1'b0;
    if (eff == 0) begin
      chk("len0_valid", out_valid, 1);
      chk("len0_done", done, 1);
    end
    for (int i = 0; i < eff; i++) begin
      if (i == abort_after) begin
        arst = 1'b1;
        #1;
        rst_chk("midjob_reset");
        @(posedge clk); #1;
        arst = 1'b0;
        void'(exp_q.pop_back());
        return;
      end
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = beat_q[i];
      hit = 1'b0;
      guard = 0;
      while (!hit && guard < 50) begin
        @(negedge clk);
        hit = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      in_valid = 1'b0;
      in_data  = $urandom;
      chk("beat_accepted", hit, 1);
      if (i == eff - 1) begin
        chk("latency_valid", out_valid, 1);
        chk("latency_done", done, 1);
      end
    end
    if (stop_in_done) return;
    // Junk beats while the result is pending must be ignored.
    in_valid = 1'b1;
    in_data  = $urandom;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b0;
    chk("result_drained", exp_q.size(), 0);
  endtask

  task automatic job16_run();
    int cnt, guard;
    longint unsigned tot;
    exp_t e;
    tot = 200 * (255 + 255);
    e.ovf  = (tot > 64'hFFFF);
    e.data = e.ovf ? (SAT ? 64'hFFFF : (tot % 65536)) : tot;
    exp16_q.push_back(e);
    start16 = 1'b1;
    len16   = LENW'(200);
    @(posedge clk); #1;
    start16    = 1'b0;
    in_valid16 = 1'b1;
    in_data16  = 16'hFFFF;
    cnt = 0;
    guard = 0;
    while (cnt < 200 && guard < 400) begin
      @(negedge clk);
      if (in_ready16) cnt++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid16 = 1'b0;
    chk("w16_beats", cnt, 200);
    guard = 0;
    while (exp16_q.size() != 0 && guard < 200) begin @(posedge clk); #1; guard++; end
    chk("w16_drained", exp16_q.size(), 0);
  endtask

  initial begin
    #3ms;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_chk("reset");
    arst = 1'b0;
    @(posedge clk); #1;

    beat_q = {32'h0403_0201};
    job(1, 0, -1, 1'b0);

    beat_q = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    job(4, 0, -1, 1'b0);
    job(4, 3, -1, 1'b0);

    job(0, 0, -1, 1'b0);

    // Backpressured result, with starts offered during DONE and on the accept cycle.
    rdy_pct = 0;
    beat_q = {32'h1122_3344, 32'h5566_7788};
    @(posedge clk); #1;
    job(2, 0, -1, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    chk("stall_valid", out_valid, 1);
    start = 1'b1;
    len   = LENW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    chk("stall_start_valid", out_valid, 1);
    chk("stall_start_in_ready", in_ready, 0);
    start   = 1'b1;
    rdy_pct = 100;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_start_busy", busy, 0);
    chk("accept_start_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("accept_start_idle", busy, 0);
    chk("stall_drained", exp_q.size(), 0);

    job16_run();

    beat_q.delete();
    for (int i = 0; i < 4; i++) beat_q.push_back($urandom);
    job(4, 0, 2, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("post_reset_idle_busy", busy, 0);
    chk("post_reset_no_valid", out_valid, 0);
    beat_q = {32'h0101_0101};
    job(1, 0, -1, 1'b0);

    beat_q.delete();
    for (int i = 0; i < 300; i++) beat_q.push_back($urandom);
    job(300, 0, -1, 1'b0);

    rdy_pct = 60;
    for (int j = 0; j < 15; j++) begin
      int l;
      l = int'($urandom_range(1, 12));
      beat_q.delete();
      for (int i = 0; i < l; i++) beat_q.push_back($urandom);
      job(l, -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
